// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the systolic-array front end.
//   ARRAY_N_DEFAULT    : default rows = columns of the PE array
//   DATA_WIDTH_DEFAULT : default weight word width
//   weight_t           : signed fixed-point weight word
//   feeder_state_t     : weight feeder FSM states (FILL, DRAIN)
//   burst_width()      : bits needed for a burst counter that spans 0..2N
//   index_width()      : bits needed to index N slots (never less than 1)
// ---------------------------------------------------------------------------
package tpu_pkg;

    localparam int ARRAY_N_DEFAULT    = 2;
    localparam int DATA_WIDTH_DEFAULT = 16;

    typedef logic signed [DATA_WIDTH_DEFAULT-1:0] weight_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } feeder_state_t;

    function automatic int burst_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_feeder_if.sv
// ---------------------------------------------------------------------------
// weight_feeder_if
// Valid/ready weight stream from the unified buffer into the weight feeder.
//   w_data_in   : weight word
//   w_valid_in  : word valid
//   w_ready_out : feeder can accept a word this cycle
// Modports: master (buffer side), slave (feeder side).
// ---------------------------------------------------------------------------
interface weight_feeder_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] w_data_in;
    logic                  w_valid_in;
    logic                  w_ready_out;

    modport master (
        output w_data_in,
        output w_valid_in,
        input  w_ready_out
    );

    modport slave (
        input  w_data_in,
        input  w_valid_in,
        output w_ready_out
    );
endinterface

// File: rtl/weight_skew_col.sv
// ---------------------------------------------------------------------------
// weight_skew_col
// Per-column skew logic: given the burst index of a drain and this column's
// staged slots, selects the slot to send and raises accept/switch.
//   active   : a drain beat is being produced
//   burst    : burst counter b of that beat
//   slots    : this column's staged words, slot s at index s
//   weight   : slots[b-COL] inside the accept window, else 0
//   accept_w : high for COL <= b < COL+ARRAY_N
//   switch_w : high at b == COL+ARRAY_N
// Purely combinational; the top level registers the results.
// ---------------------------------------------------------------------------
module weight_skew_col
    import tpu_pkg::*;
#(
    parameter int ARRAY_N    = ARRAY_N_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int COL        = 0,
    parameter int BW         = burst_width(ARRAY_N),
    parameter int SW         = index_width(ARRAY_N)
) (
    input  logic                               active,
    input  logic [BW-1:0]                      burst,
    input  logic [ARRAY_N-1:0][DATA_WIDTH-1:0] slots,
    output logic [DATA_WIDTH-1:0]              weight,
    output logic                               accept_w,
    output logic                               switch_w
);

    logic [BW-1:0] rel_s;
    logic [SW-1:0] slot_s;
    logic          in_window_s;

    // Column window decode: each column lags the previous one by one beat.
    always_comb begin
        rel_s       = burst - BW'(COL);
        slot_s      = rel_s[SW-1:0];
        in_window_s = (burst >= BW'(COL)) && (rel_s < BW'(ARRAY_N));
        weight      = '0;
        accept_w    = 1'b0;
        switch_w    = 1'b0;
        if (active && in_window_s) begin
            accept_w = 1'b1;
            weight   = slots[slot_s];
        end else begin
            accept_w = 1'b0;
            weight   = '0;
        end
        if (active && (burst == BW'(COL + ARRAY_N))) begin
            switch_w = 1'b1;
        end else begin
            switch_w = 1'b0;
        end
    end

endmodule

// File: rtl/weight_feeder.sv
// ---------------------------------------------------------------------------
// weight_feeder
// Collects an ARRAY_N x ARRAY_N weight tile (column-major, deepest row first)
// from a valid/ready stream and replays it into the top PE of every column
// with a one-beat-per-column diagonal skew, followed by the switch pulse.
// Ports:
//   clk, rst          : clock; asynchronous active-low reset
//   enable            : 0 clears everything synchronously
//   w_bus (slave)     : w_data_in / w_valid_in / w_ready_out stream
//   col_weight_out    : column c weight at [c*DATA_WIDTH +: DATA_WIDTH]
//   col_accept_w_out  : per-column accept strobe
//   col_switch_out    : per-column switch strobe
//   busy_out          : high on the 2*ARRAY_N weight/switch beats
//   done_out          : one-cycle pulse after the last column switches
// Option macro WEIGHT_FEEDER_DBUF_EN: ping-pong staging so the next tile
// fills while the current one drains. Assumes ARRAY_N >= 2 so the final
// word of a tile is never needed on the first drain beat.
// ---------------------------------------------------------------------------
module weight_feeder
    import tpu_pkg::*;
#(
    parameter int ARRAY_N    = ARRAY_N_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    weight_feeder_if.slave                w_bus,
    output logic [ARRAY_N*DATA_WIDTH-1:0] col_weight_out,
    output logic [ARRAY_N-1:0]            col_accept_w_out,
    output logic [ARRAY_N-1:0]            col_switch_out,
    output logic                          busy_out,
    output logic                          done_out
);

    localparam int            BW     = burst_width(ARRAY_N);
    localparam int            SW     = index_width(ARRAY_N);
    // Burst value of the done beat; DRAIN holds one extra beat to emit it.
    localparam logic [BW-1:0] DONE_B = BW'(2 * ARRAY_N);
`ifdef WEIGHT_FEEDER_DBUF_EN
    localparam int            NBANK   = 2;
    localparam bit            DBUF_EN = 1'b1;
`else
    localparam int            NBANK   = 1;
    localparam bit            DBUF_EN = 1'b0;
`endif

    feeder_state_t state_r, state_n_s;
    logic [BW-1:0] burst_r, burst_n_s;
    logic [SW-1:0] wr_col_r, wr_col_n_s;
    logic [SW-1:0] wr_slot_r, wr_slot_n_s;
    logic          wbank_r, wbank_n_s, rbank_n_s;
    logic          pending_r, pending_n_s;
    logic          ready_r, ready_n_s;
    logic          xfer_s, last_s, drain_n_s;

    logic [DATA_WIDTH-1:0] staging_r [NBANK][ARRAY_N][ARRAY_N];

    logic [ARRAY_N-1:0][ARRAY_N-1:0][DATA_WIDTH-1:0] rd_cols_s;
    logic [ARRAY_N-1:0][DATA_WIDTH-1:0]              skew_weight_s;
    logic [ARRAY_N-1:0]                              skew_accept_s;
    logic [ARRAY_N-1:0]                              skew_switch_s;

    logic [ARRAY_N-1:0][DATA_WIDTH-1:0] col_weight_r;
    logic [ARRAY_N-1:0]                 col_accept_r;
    logic [ARRAY_N-1:0]                 col_switch_r;
    logic                               busy_r;
    logic                               done_r;

    // Next-state logic: write pointers, FSM, burst counter and bank swap.
    always_comb begin
        state_n_s   = state_r;
        burst_n_s   = burst_r;
        wr_col_n_s  = wr_col_r;
        wr_slot_n_s = wr_slot_r;
        wbank_n_s   = wbank_r;
        pending_n_s = pending_r;
        xfer_s      = w_bus.w_valid_in && ready_r;
        last_s      = xfer_s && (wr_col_r == SW'(ARRAY_N - 1))
                             && (wr_slot_r == SW'(ARRAY_N - 1));

        if (xfer_s) begin
            if (wr_slot_r == SW'(ARRAY_N - 1)) begin
                wr_slot_n_s = '0;
                if (wr_col_r == SW'(ARRAY_N - 1)) begin
                    wr_col_n_s = '0;
                end else begin
                    wr_col_n_s = wr_col_r + SW'(1);
                end
            end else begin
                wr_slot_n_s = wr_slot_r + SW'(1);
                wr_col_n_s  = wr_col_r;
            end
        end else begin
            wr_slot_n_s = wr_slot_r;
            wr_col_n_s  = wr_col_r;
        end

        case (state_r)
            FILL: begin
                burst_n_s = '0;
                if (last_s) begin
                    state_n_s = DRAIN;
                    wbank_n_s = DBUF_EN ? ~wbank_r : wbank_r;
                end else begin
                    state_n_s = FILL;
                end
            end
            DRAIN: begin
                if (burst_r == DONE_B) begin
                    burst_n_s = '0;
                    // A shadow tile that is already full (or completes now)
                    // starts draining on the very next beat.
                    if (pending_r || last_s) begin
                        state_n_s   = DRAIN;
                        wbank_n_s   = DBUF_EN ? ~wbank_r : wbank_r;
                        pending_n_s = 1'b0;
                    end else begin
                        state_n_s = FILL;
                    end
                end else begin
                    burst_n_s = burst_r + BW'(1);
                    if (last_s) begin
                        pending_n_s = 1'b1;
                    end else begin
                        pending_n_s = pending_r;
                    end
                end
            end
            default: begin
                state_n_s   = FILL;
                burst_n_s   = '0;
                pending_n_s = 1'b0;
            end
        endcase

        drain_n_s = (state_n_s == DRAIN);
        // The drained bank is always the one not being filled.
        rbank_n_s = DBUF_EN ? ~wbank_n_s : wbank_n_s;
        ready_n_s = DBUF_EN ? !pending_n_s : (state_n_s == FILL);
    end

    // Gather the staged columns of the bank that the next beat reads.
    always_comb begin
        rd_cols_s = '0;
        for (int c = 0; c < ARRAY_N; c++) begin
            for (int s = 0; s < ARRAY_N; s++) begin
                rd_cols_s[c][s] = staging_r[rbank_n_s][c][s];
            end
        end
    end

    for (genvar c = 0; c < ARRAY_N; c++) begin : g_col
        weight_skew_col #(
            .ARRAY_N    (ARRAY_N),
            .DATA_WIDTH (DATA_WIDTH),
            .COL        (c),
            .BW         (BW),
            .SW         (SW)
        ) u_skew (
            .active   (drain_n_s),
            .burst    (burst_n_s),
            .slots    (rd_cols_s[c]),
            .weight   (skew_weight_s[c]),
            .accept_w (skew_accept_s[c]),
            .switch_w (skew_switch_s[c])
        );
    end

    // Control state registers with async reset and enable-driven clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= FILL;
            burst_r   <= '0;
            wr_col_r  <= '0;
            wr_slot_r <= '0;
            wbank_r   <= 1'b0;
            pending_r <= 1'b0;
            ready_r   <= 1'b0;
        end else if (!enable) begin
            state_r   <= FILL;
            burst_r   <= '0;
            wr_col_r  <= '0;
            wr_slot_r <= '0;
            wbank_r   <= 1'b0;
            pending_r <= 1'b0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            burst_r   <= burst_n_s;
            wr_col_r  <= wr_col_n_s;
            wr_slot_r <= wr_slot_n_s;
            wbank_r   <= wbank_n_s;
            pending_r <= pending_n_s;
            ready_r   <= ready_n_s;
        end
    end

    // Staging storage: accepted words land at [bank][column][slot].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int c = 0; c < ARRAY_N; c++) begin
                    for (int s = 0; s < ARRAY_N; s++) begin
                        staging_r[b][c][s] <= '0;
                    end
                end
            end
        end else if (!enable) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int c = 0; c < ARRAY_N; c++) begin
                    for (int s = 0; s < ARRAY_N; s++) begin
                        staging_r[b][c][s] <= '0;
                    end
                end
            end
        end else if (xfer_s) begin
            staging_r[wbank_r][wr_col_r][wr_slot_r] <= w_bus.w_data_in;
        end else begin
            staging_r[wbank_r][wr_col_r][wr_slot_r] <= staging_r[wbank_r][wr_col_r][wr_slot_r];
        end
    end

    // Output registers, loaded with the beat that the next state describes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_weight_r <= '0;
            col_accept_r <= '0;
            col_switch_r <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else if (!enable) begin
            col_weight_r <= '0;
            col_accept_r <= '0;
            col_switch_r <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            col_weight_r <= skew_weight_s;
            col_accept_r <= skew_accept_s;
            col_switch_r <= skew_switch_s;
            busy_r       <= drain_n_s && (burst_n_s < DONE_B);
            done_r       <= drain_n_s && (burst_n_s == DONE_B);
        end
    end

    assign w_bus.w_ready_out = ready_r;
    assign col_weight_out    = col_weight_r;
    assign col_accept_w_out  = col_accept_r;
    assign col_switch_out    = col_switch_r;
    assign busy_out          = busy_r;
    assign done_out          = done_r;

endmodule
